// File: rtl/divide_sched_f32_pkg.sv
// Shared encodings and fp32 constants for the divide scheduler and its arbiter.
package divide_sched_f32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_DIV0    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_INF_EXP = 8'hFF;

    // Signed infinity returned for x/0, sign is the xor of the operand signs.
    function automatic logic [31:0] fp32_signed_inf(input logic sign);
        return {sign, FP32_INF_EXP, 23'd0};
    endfunction

    function automatic logic fp32_is_zero(input logic [31:0] x);
        return (x[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/divide_sched_f32_rr_arbiter.sv
// Round-robin picker: first requester after ptr (with wrap) wins.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/divide_sched_f32.sv
// Shares one fp32 divide unit among NREQ requesters, one transaction in flight,
// with divide-by-zero bypass and a completion timeout.
module divide_sched_f32
    import divide_sched_f32_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 32,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_num,
    input  logic [NREQ*32-1:0] req_den,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_quo,
    output logic [1:0]        rsp_err,
    input  logic              rsp_ready,
    output logic              du_start,
    output logic [31:0]       du_num,
    output logic [31:0]       du_den,
    input  logic              du_done,
    input  logic [31:0]       du_quo,
    output logic              busy
);

    localparam int CNTW = $clog2(TIMEOUT) + 1;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [31:0]     num_q;
    logic [31:0]     den_q;
    logic [31:0]     quo_q;
    err_t            err_q;
    logic [CNTW-1:0] wait_cnt;
    logic [CNTW-1:0] cnt_next;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [31:0]     num_sel;
    logic [31:0]     den_sel;
    logic            in_du;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign num_sel  = req_num[32*gnt_idx +: 32];
    assign den_sel  = req_den[32*gnt_idx +: 32];
    assign cnt_next = wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
        if (!rst) begin
            state    <= IDLE;
            ptr      <= IDW'(NREQ - 1);
            id_q     <= '0;
            num_q    <= '0;
            den_q    <= '0;
            quo_q    <= '0;
            err_q    <= ERR_OK;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        ptr   <= gnt_idx;
                        id_q  <= gnt_idx;
                        num_q <= num_sel;
                        den_q <= den_sel;
                        if (fp32_is_zero(den_sel)) begin
                            quo_q <= fp32_signed_inf(num_sel[31] ^ den_sel[31]);
                            err_q <= ERR_DIV0;
                            state <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still delivers the real quotient.
                    if (du_done) begin
                        quo_q <= du_quo;
                        err_q <= ERR_OK;
                        state <= RESP;
                    end else if (cnt_next == CNTW'(TIMEOUT - 1)) begin
                        quo_q <= FP32_QNAN;
                        err_q <= ERR_TIMEOUT;
                        state <= RESP;
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accept pulse is combinational with the grant; rst gating keeps it quiet during reset.
    assign req_ready = (rst && state == IDLE) ? gnt : '0;

    assign in_du    = (state == ISSUE) || (state == WAIT);
    assign du_start = (state == ISSUE);
    assign du_num   = in_du ? num_q : '0;
    assign du_den   = in_du ? den_q : '0;

    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_valid ? id_q  : '0;
    assign rsp_quo   = rsp_valid ? quo_q : '0;
    assign rsp_err   = rsp_valid ? err_q : ERR_OK;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_divide_sched_f32.sv
// Directed bench for divide_sched_f32: stimulus pushes expected responses, a monitor pops them.
module tb_divide_sched_f32;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_num;
    logic [NREQ*32-1:0] req_den;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_quo;
    logic [1:0]        rsp_err;
    logic              rsp_ready;
    logic              du_start;
    logic [31:0]       du_num;
    logic [31:0]       du_den;
    logic              du_done;
    logic [31:0]       du_quo;
    logic              busy;

    divide_sched_f32 #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_den   (req_den),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_quo   (rsp_quo),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .du_start  (du_start),
        .du_num    (du_num),
        .du_den    (du_den),
        .du_done   (du_done),
        .du_quo    (du_quo),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [31:0] quo;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Divide-unit stub configuration, written by the stimulus before each start.
    int          exp_start;
    int          du_lat;
    logic [31:0] du_res;
    logic [31:0] exp_num;
    logic [31:0] exp_den;

    logic [31:0] num_tab [4];
    logic [31:0] quo_tab [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] num, input logic [31:0] den);
        req_num[32*i +: 32] = num;
        req_den[32*i +: 32] = den;
    endtask

    task automatic push_exp(input int id, input logic [31:0] quo, input logic [1:0] err, input int c);
        exp_t e;
        e.id  = id;
        e.quo = quo;
        e.err = err;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Divide-unit stub: checks start timing and operands, answers after du_lat cycles.
    initial begin
        du_done = 1'b0;
        du_quo  = '0;
        forever begin
            @(negedge clk);
            if (du_start) begin
                check("du_start_cycle", 32'(cyc), 32'(exp_start));
                check("du_num", du_num, exp_num);
                check("du_den", du_den, exp_den);
                repeat (du_lat) @(posedge clk);
                #1;
                du_done = 1'b1;
                du_quo  = du_res;
                @(posedge clk);
                #1;
                du_done = 1'b0;
                du_quo  = '0;
            end
        end
    end

    // Response monitor: each new rsp_valid must match the oldest expectation.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_quo", rsp_quo, e.quo);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_gnt;
        int g;
        int id;

        num_tab = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};
        quo_tab = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        rst       = 1'b0;
        req_valid = '0;
        req_num   = '0;
        req_den   = '0;
        rsp_ready = 1'b1;
        exp_start = -1;
        du_lat    = 0;
        du_res    = '0;
        exp_num   = '0;
        exp_den   = '0;

        // Held in reset with every requester pending: all outputs stay low.
        #2 req_valid = '1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_du_start", 32'(du_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        goto(3);
        rst = 1'b1;

        // 6.0 / 2.0 from requester 1, divide unit answers after 5 cycles.
        goto(5);
        set_req(1, 32'h40C0_0000, 32'h4000_0000);
        req_valid = 4'b0010;
        exp_start = 6;
        du_lat    = 5;
        du_res    = 32'h4040_0000;
        exp_num   = 32'h40C0_0000;
        exp_den   = 32'h4000_0000;
        @(negedge clk);
        check("t1_grant", 32'(req_ready), 32'h2);
        check("t1_idle_busy", 32'(busy), 32'd0);
        push_exp(1, 32'h4040_0000, 2'b00, 12);
        goto(6);
        req_valid = '0;
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);

        // Fresh reset, then all four held high: grants rotate from requester 0.
        goto(14);
        rst = 1'b0;
        goto(15);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, num_tab[i], 32'h4000_0000);
        goto(16);
        req_valid = '1;
        for (int n = 0; n < 8; n++) begin
            g  = 16 + 5 * n;
            id = n % 4;
            goto(g);
            exp_start = g + 1;
            du_lat    = 2;
            du_res    = quo_tab[id];
            exp_num   = num_tab[id];
            exp_den   = 32'h4000_0000;
            @(negedge clk);
            exp_gnt = 4'(1 << id);
            check("rr_grant", 32'(req_ready), 32'(exp_gnt));
            push_exp(id, quo_tab[id], 2'b00, g + 4);
        end
        goto(55);
        req_valid = '0;

        // Divide by +0 and -0 bypass the divide unit.
        goto(58);
        exp_start = -1;
        set_req(2, 32'hBF80_0000, 32'h0000_0000);
        req_valid = 4'b0100;
        @(negedge clk);
        check("dz1_grant", 32'(req_ready), 32'h4);
        push_exp(2, 32'hFF80_0000, 2'b01, 59);
        goto(59);
        req_valid = '0;
        goto(61);
        set_req(0, 32'h4000_0000, 32'h8000_0000);
        req_valid = 4'b0001;
        @(negedge clk);
        check("dz2_grant", 32'(req_ready), 32'h1);
        push_exp(0, 32'hFF80_0000, 2'b01, 62);
        goto(62);
        req_valid = '0;

        // Denormal denominator goes to the unit, which answers too late: timeout.
        goto(64);
        set_req(1, 32'h3F80_0000, 32'h0000_0001);
        req_valid = 4'b0010;
        exp_start = 65;
        du_lat    = TIMEOUT + 3;
        du_res    = 32'h3F80_0000;
        exp_num   = 32'h3F80_0000;
        exp_den   = 32'h0000_0001;
        @(negedge clk);
        check("to_grant", 32'(req_ready), 32'h2);
        push_exp(1, 32'h7FC0_0000, 2'b10, 65 + TIMEOUT);
        goto(65);
        req_valid = '0;
        goto(65 + TIMEOUT + 3);
        @(negedge clk);
        check("late_done_busy", 32'(busy), 32'd0);
        check("late_done_rsp", 32'(rsp_valid), 32'd0);
        goto(101);
        @(negedge clk);
        check("late_done_after", 32'(busy), 32'd0);

        // Done on the last wait cycle beats the timeout.
        goto(103);
        set_req(2, 32'h4100_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        exp_start = 104;
        du_lat    = TIMEOUT - 1;
        du_res    = 32'h4080_0000;
        exp_num   = 32'h4100_0000;
        exp_den   = 32'h4000_0000;
        @(negedge clk);
        check("race_grant", 32'(req_ready), 32'h4);
        push_exp(2, 32'h4080_0000, 2'b00, 104 + TIMEOUT);
        goto(104);
        req_valid = '0;

        // Back-pressure: response held 10 cycles while requester 1 waits.
        goto(138);
        rsp_ready = 1'b0;
        exp_start = -1;
        set_req(3, 32'h3F80_0000, 32'h8000_0000);
        set_req(1, 32'h4000_0000, 32'h4000_0000);
        req_valid = 4'b1010;
        @(negedge clk);
        check("bp_grant", 32'(req_ready), 32'h8);
        push_exp(3, 32'hFF80_0000, 2'b01, 139);
        goto(139);
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            goto(139 + k);
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id", 32'(rsp_id), 32'd3);
            check("bp_quo", rsp_quo, 32'hFF80_0000);
            check("bp_err", 32'(rsp_err), 32'd1);
            check("bp_no_grant", 32'(req_ready), 32'd0);
        end
        goto(149);
        rsp_ready = 1'b1;
        exp_start = 151;
        du_lat    = 20;
        du_res    = 32'h3F80_0000;
        exp_num   = 32'h4000_0000;
        exp_den   = 32'h4000_0000;
        goto(150);
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'h2);
        goto(151);
        req_valid = '0;

        // Reset while waiting on the divide unit abandons the transaction.
        goto(155);
        rst = 1'b0;
        set_req(0, 32'h4000_0000, 32'h0000_0000);
        req_valid = '1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_du_start", 32'(du_start), 32'd0);
        check("mid_rst_du_num", du_num, 32'd0);
        check("mid_rst_du_den", du_den, 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_quo", rsp_quo, 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        goto(157);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'h1);
        push_exp(0, 32'h7F80_0000, 2'b01, 158);
        goto(158);
        req_valid = '0;
        goto(171);
        @(negedge clk);
        check("abandoned_done_busy", 32'(busy), 32'd0);
        check("abandoned_done_rsp", 32'(rsp_valid), 32'd0);

        goto(175);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
